gate_arbiter: RTL

//  Arbitrates a single-lane barrier gate shared by the entry and exit sensor requesters.

---
 rtl/gate_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gate_arbiter.sv
// Barrier-gate arbiter: shares one gate between the entry and exit requesters,
// sequences OPENING/PASS/CLOSING and reports completed passages as inc/dec pulses.
module gate_arbiter #(
  parameter int OCC_W        = 6,
  parameter int CAPACITY     = 40,
  parameter int OPEN_CYC     = 4,
  parameter int PASS_TIMEOUT = 16,
  parameter int CLOSE_CYC    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_ent,
  input  logic             req_sai,
  input  logic             pass_done,
  input  logic [OCC_W-1:0] occupancy,
  input  logic             alerta,
  input  logic             emergencia,
  output logic             gate_open,
  output logic             grant_ent,
  output logic             grant_sai,
  output logic             increment,
  output logic             decrement,
  output logic             full,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OPENING = 3'd1;
  localparam logic [2:0] S_PASS    = 3'd2;
  localparam logic [2:0] S_CLOSING = 3'd3;
  localparam logic [2:0] S_EMERG   = 3'd4;

  localparam int T_MAX_OP = (OPEN_CYC > PASS_TIMEOUT) ? OPEN_CYC : PASS_TIMEOUT;
  localparam int T_MAX    = (T_MAX_OP > CLOSE_CYC) ? T_MAX_OP : CLOSE_CYC;
  localparam int TW       = $clog2(T_MAX + 1);

  localparam logic [TW-1:0]    T_SAT      = TW'(T_MAX);
  localparam logic [TW-1:0]    OPEN_LAST  = TW'(OPEN_CYC - 1);
  localparam logic [TW-1:0]    PASS_LAST  = TW'(PASS_TIMEOUT - 1);
  localparam logic [TW-1:0]    CLOSE_LAST = TW'(CLOSE_CYC - 1);
  localparam logic [OCC_W:0]   CAP_V      = (OCC_W + 1)'(CAPACITY);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_sai_q, last_sai_d;
  logic          gate_open_q, gate_open_d;
  logic          grant_ent_q, grant_ent_d;
  logic          grant_sai_q, grant_sai_d;
  logic          increment_q, increment_d;
  logic          decrement_q, decrement_d;
  logic          timeout_q, timeout_d;

  logic ent_ok, sai_ok, pick_ent, pick_sai;

  assign full   = ({1'b0, occupancy} >= CAP_V);
  assign ent_ok = req_ent & ~full & ~alerta & ~emergencia;
  assign sai_ok = req_sai & (occupancy != '0);

  // On a tie the direction that did not win last time is served.
  assign pick_ent = ent_ok & (~sai_ok | last_sai_q);
  assign pick_sai = sai_ok & (~ent_ok | ~last_sai_q);

  always_comb begin
    // NOTE: every next-state signal is given a default before any branch so no path infers a latch.
    state_d     = state_q;
    timer_d     = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
    last_sai_d  = last_sai_q;
    gate_open_d = gate_open_q;
    grant_ent_d = grant_ent_q;
    grant_sai_d = grant_sai_q;
    increment_d = 1'b0;
    decrement_d = 1'b0;
    timeout_d   = 1'b0;

    if (emergencia) begin
      state_d     = S_EMERG;
      gate_open_d = 1'b1;
      grant_ent_d = 1'b0;
      grant_sai_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          gate_open_d = 1'b0;
          grant_ent_d = 1'b0;
          grant_sai_d = 1'b0;
          if (pick_ent) begin
            state_d     = S_OPENING;
            gate_open_d = 1'b1;
            grant_ent_d = 1'b1;
            last_sai_d  = 1'b0;
          end else if (pick_sai) begin
            state_d     = S_OPENING;
            gate_open_d = 1'b1;
            grant_sai_d = 1'b1;
            last_sai_d  = 1'b1;
          end
        end

        S_OPENING: begin
          if (timer_q == OPEN_LAST) state_d = S_PASS;
        end

        S_PASS: begin
          // A vehicle clearing on the last allowed cycle still counts as a passage.
          if (pass_done) begin
            state_d     = S_CLOSING;
            gate_open_d = 1'b0;
            grant_ent_d = 1'b0;
            grant_sai_d = 1'b0;
            increment_d = grant_ent_q;
            decrement_d = grant_sai_q;
          end else if (timer_q == PASS_LAST) begin
            state_d     = S_CLOSING;
            gate_open_d = 1'b0;
            grant_ent_d = 1'b0;
            grant_sai_d = 1'b0;
            timeout_d   = 1'b1;
          end
        end

        S_CLOSING: begin
          gate_open_d = 1'b0;
          grant_ent_d = 1'b0;
          grant_sai_d = 1'b0;
          if (timer_q == CLOSE_LAST) state_d = S_IDLE;
        end

        S_EMERG: begin
          state_d     = S_CLOSING;
          gate_open_d = 1'b0;
          grant_ent_d = 1'b0;
          grant_sai_d = 1'b0;
        end

        default: begin
          state_d     = S_IDLE;
          gate_open_d = 1'b0;
          grant_ent_d = 1'b0;
          grant_sai_d = 1'b0;
        end
      endcase
    end

    if (state_d != state_q) timer_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      last_sai_q  <= 1'b1;
      gate_open_q <= 1'b0;
      grant_ent_q <= 1'b0;
      grant_sai_q <= 1'b0;
      increment_q <= 1'b0;
      decrement_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_sai_q  <= last_sai_d;
      gate_open_q <= gate_open_d;
      grant_ent_q <= grant_ent_d;
      grant_sai_q <= grant_sai_d;
      increment_q <= increment_d;
      decrement_q <= decrement_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign grant_ent   = grant_ent_q;
  assign grant_sai   = grant_sai_q;
  assign increment   = increment_q;
  assign decrement   = decrement_q;
  assign timeout_err = timeout_q;

  a_grant_mutex : assert property (@(posedge clk) disable iff (reset)
    !(grant_ent_q && grant_sai_q));
  a_count_mutex : assert property (@(posedge clk) disable iff (reset)
    !(increment_q && decrement_q));

endmodule
